lzw_compressor: RTL and testbench

Self-contained LZW compressor. It encodes a fixed 19-byte message held in an internal ROM into up to 14 twelve-bit codes and presents them on a parallel output array. It needs no input data port: it runs from reset release to completion, then holds its result. It serves as a standalone demonstrator of the encoder datapath, a dictionary with parallel lookup plus a sequencer, ahead of a streaming variant.

---
 rtl/lzw_pkg.sv | 35 +++
 rtl/lzw_compressor_if.sv | 28 ++
 rtl/lzw_dict.sv | 40 ++++
 rtl/lzw_compressor.sv | 124 ++++++++++++
 tb/tb_lzw_compressor.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/lzw_pkg.sv
// Shared constants, message ROM, state encoding and dictionary entry layout
// for the LZW compressor demonstrator.
package lzw_pkg;

  localparam int WIDTH        = 8;
  localparam int CODE_W       = 12;
  localparam int N_CODES      = 14;
  localparam int DICT_ENTRIES = 64;
  localparam int MSG_LEN      = 19;
  localparam int LIT_CODES    = 1 << WIDTH;
  localparam int ROM_AW       = $clog2(MSG_LEN);

  // "TOBEORNOTTOBEORTOBE", index 0 first
  localparam logic [WIDTH-1:0] MSG_ROM [MSG_LEN] = '{
    8'h54, 8'h4F, 8'h42, 8'h45, 8'h4F, 8'h52, 8'h4E, 8'h4F, 8'h54, 8'h54,
    8'h4F, 8'h42, 8'h45, 8'h4F, 8'h52, 8'h54, 8'h4F, 8'h42, 8'h45
  };

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    DONE
  } lzw_state_e;

  typedef struct packed {
    logic              valid;
    logic [CODE_W-1:0] prefix;
    logic [WIDTH-1:0]  symbol;
  } dict_entry_t;

  function automatic logic [WIDTH-1:0] msgByte(input logic [ROM_AW-1:0] i);
    return (i < ROM_AW'(MSG_LEN)) ? MSG_ROM[i] : '0;
  endfunction

endpackage

// File: rtl/lzw_compressor_if.sv
// Lookup/insert bus between the LZW sequencer (master) and the dictionary
// (slave).
interface lzw_compressor_if
  import lzw_pkg::*;
#(
  parameter int IDX_W = 6
) ();

  logic [CODE_W-1:0] lookupPrefix;
  logic [WIDTH-1:0]  lookupSymbol;
  logic              hit;
  logic [CODE_W-1:0] hitCode;
  logic              insertEn;
  logic [IDX_W-1:0]  insertIdx;
  logic [CODE_W-1:0] insertPrefix;
  logic [WIDTH-1:0]  insertSymbol;

  modport master (
    output lookupPrefix, lookupSymbol, insertEn, insertIdx, insertPrefix, insertSymbol,
    input  hit, hitCode
  );

  modport slave (
    input  lookupPrefix, lookupSymbol, insertEn, insertIdx, insertPrefix, insertSymbol,
    output hit, hitCode
  );

endinterface

// File: rtl/lzw_dict.sv
// LZW dictionary: entry storage with one insert port and a fully parallel
// {prefix, symbol} match that returns the hit flag and learned code.
module lzw_dict
  import lzw_pkg::*;
#(
  parameter int ENTRIES = DICT_ENTRIES,
  parameter int IDX_W   = 6
) (
  input  logic             clk_i,
  input  logic             reset_i,
  lzw_compressor_if.slave  bus
);

  dict_entry_t entries_q [ENTRIES];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
    end else if (bus.insertEn) begin
      entries_q[bus.insertIdx] <= '{valid: 1'b1, prefix: bus.insertPrefix,
                                    symbol: bus.insertSymbol};
    end
  end

  // Keys are unique, so OR-ing the matching codes needs no priority logic.
  always_comb begin
    bus.hit     = 1'b0;
    bus.hitCode = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (entries_q[i].valid && entries_q[i].prefix == bus.lookupPrefix &&
          entries_q[i].symbol == bus.lookupSymbol) begin
        bus.hit     = 1'b1;
        bus.hitCode = bus.hitCode | CODE_W'(LIT_CODES + i);
      end
    end
  end

endmodule

// File: rtl/lzw_compressor.sv
// LZW compressor demonstrator: encodes the ROM message into registered code
// slots after reset release. Optional trace output under LZW_TRACE_EN.
module lzw_compressor #(
  parameter int N_CODES      = lzw_pkg::N_CODES,
  parameter int DICT_ENTRIES = lzw_pkg::DICT_ENTRIES
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  output logic [N_CODES-1:0][lzw_pkg::CODE_W-1:0]  compressed_o
);

  import lzw_pkg::*;

  localparam int IDX_W  = (DICT_ENTRIES > 1) ? $clog2(DICT_ENTRIES) : 1;
  localparam int FILL_W = IDX_W + 1;
  localparam int OUT_W  = $clog2(N_CODES + 1);

  lzw_state_e                      state_q, state_d;
  logic [CODE_W-1:0]               w_q, w_d;
  logic [ROM_AW-1:0]               idx_q, idx_d;
  logic [OUT_W-1:0]                outIdx_q, outIdx_d;
  // Number of learned entries; the next code to assign is 256 plus this.
  logic [FILL_W-1:0]               fill_q, fill_d;
  logic [N_CODES-1:0][CODE_W-1:0]  compressed_q, compressed_d;
  logic [WIDTH-1:0]                sym;
  logic                            emit;

  lzw_compressor_if #(.IDX_W(IDX_W)) dictBus ();

  lzw_dict #(
    .ENTRIES (DICT_ENTRIES),
    .IDX_W   (IDX_W)
  ) uDict (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (dictBus.slave)
  );

  assign sym = msgByte(idx_q);

  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    idx_d        = idx_q;
    outIdx_d     = outIdx_q;
    fill_d       = fill_q;
    compressed_d = compressed_q;
    emit         = 1'b0;

    dictBus.lookupPrefix = w_q;
    dictBus.lookupSymbol = sym;
    dictBus.insertEn     = 1'b0;
    dictBus.insertIdx    = fill_q[IDX_W-1:0];
    dictBus.insertPrefix = w_q;
    dictBus.insertSymbol = sym;

    unique case (state_q)
      RUN: begin
        idx_d = idx_q + 1'b1;
        if (dictBus.hit) begin
          w_d = dictBus.hitCode;
        end else begin
          emit = 1'b1;
          if (fill_q < FILL_W'(DICT_ENTRIES)) begin
            dictBus.insertEn = 1'b1;
            fill_d           = fill_q + 1'b1;
          end
          w_d = CODE_W'(sym);
        end
        if (idx_q == ROM_AW'(MSG_LEN - 1)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        emit    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
      end
      default: begin
      end
    endcase

    // Emissions past the last slot are dropped and the slot index saturates.
    if (emit && outIdx_q < OUT_W'(N_CODES)) begin
      compressed_d[outIdx_q] = w_q;
      outIdx_d               = outIdx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= RUN;
      w_q          <= CODE_W'(msgByte('0));
      idx_q        <= ROM_AW'(1);
      outIdx_q     <= '0;
      fill_q       <= '0;
      compressed_q <= '0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      idx_q        <= idx_d;
      outIdx_q     <= outIdx_d;
      fill_q       <= fill_d;
      compressed_q <= compressed_d;
    end
  end

  assign compressed_o = compressed_q;

`ifdef LZW_TRACE_EN
  always @(posedge clk_i) begin
    if (!reset_i && emit && outIdx_q < OUT_W'(N_CODES)) begin
      $display("LZW slot %0d code %0d", outIdx_q, w_q);
    end
    if (!reset_i && state_q == FLUSH) begin
      $display("LZW done, %0d codes", outIdx_d);
    end
  end
`else
  // Quiet build: no simulation output.
`endif

endmodule

// File: tb/tb_lzw_compressor.sv
// Self-checking bench for lzw_compressor: a string-level LZW model checked every
// cycle against a full-dictionary and a two-entry-dictionary instance.
module tb_lzw_compressor;

  localparam int NC = 14;

  localparam int ZERO  [NC] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  localparam int EDGE9 [NC] = '{84, 79, 66, 69, 79, 82, 78, 79, 84, 0, 0, 0, 0, 0};
  localparam int FULL  [NC] = '{84, 79, 66, 69, 79, 82, 78, 79, 84, 256, 258, 260, 265, 69};
  localparam int TRUNC [NC] = '{84, 79, 66, 69, 79, 82, 78, 79, 84, 256, 66, 69, 79, 82};

  logic                 clock;
  logic                 reset;
  logic [NC-1:0][11:0]  outBig;
  logic [NC-1:0][11:0]  outSmall;

  int   errors = 0;
  int   checks = 0;
  int   relEdge = 0;
  logic armed = 1'b0;

  string msg = "TOBEORNOTTOBEORTOBE";

  lzw_compressor dut (
    .clk_i        (clock),
    .reset_i      (reset),
    .compressed_o (outBig)
  );

  lzw_compressor #(.DICT_ENTRIES(2)) dutSmall (
    .clk_i        (clock),
    .reset_i      (reset),
    .compressed_o (outSmall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edges since the last reset edge; edge 1 is the first edge with reset low.
  always @(posedge clock) begin
    if (reset) begin
      relEdge <= 0;
      armed   <= 1'b1;
    end else begin
      relEdge <= relEdge + 1;
    end
  end

  // Plain string-dictionary LZW: which slots are filled after a given edge count.
  task automatic modelSlots(input int dictEntries, input int edges, output int slots [NC]);
    int    dict [string];
    string w, c, wc;
    int    nextCode, outIdx, steps, code;
    for (int i = 0; i < NC; i++) slots[i] = 0;
    steps    = (edges > msg.len()) ? msg.len() : edges;
    w        = $sformatf("%c", msg[0]);
    nextCode = 256;
    outIdx   = 0;
    for (int k = 1; k <= steps; k++) begin
      c  = (k < msg.len()) ? $sformatf("%c", msg[k]) : "";
      wc = {w, c};
      if (k < msg.len() && dict.exists(wc)) begin
        w = wc;
      end else begin
        code = (w.len() == 1) ? int'(w[0]) : dict[w];
        if (outIdx < NC) begin
          slots[outIdx] = code;
          outIdx++;
        end
        if (k < msg.len()) begin
          if (nextCode < 256 + dictEntries) begin
            dict[wc] = nextCode;
            nextCode++;
          end
          w = c;
        end
      end
    end
  endtask

  always @(negedge clock) begin
    int expBig [NC];
    int expSmall [NC];
    if (armed) begin
      modelSlots(64, relEdge, expBig);
      modelSlots(2, relEdge, expSmall);
      for (int i = 0; i < NC; i++) begin
        checks++;
        if (outBig[i] !== 12'(expBig[i])) begin
          errors++;
          $display("[TB] FAIL model big slot %0d edge %0d: got %0d, want %0d",
                   i, relEdge, outBig[i], expBig[i]);
        end
        checks++;
        if (outSmall[i] !== 12'(expSmall[i])) begin
          errors++;
          $display("[TB] FAIL model small slot %0d edge %0d: got %0d, want %0d",
                   i, relEdge, outSmall[i], expSmall[i]);
        end
      end
    end
  end

  task automatic applyStimulus(input logic resetVal, input int cycles);
    reset = resetVal;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input logic [NC-1:0][11:0] act,
                             input int exp [NC]);
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (act[i] !== 12'(exp[i])) begin
        errors++;
        $display("[TB] FAIL %s slot %0d: got %0d, want %0d", name, i, act[i], exp[i]);
      end
    end
  endtask

  initial begin
    applyStimulus(1'b1, 5);
    checkOutput("reset big", outBig, ZERO);
    checkOutput("reset small", outSmall, ZERO);

    applyStimulus(1'b0, 9);
    checkOutput("edge9 big", outBig, EDGE9);
    checkOutput("edge9 small", outSmall, EDGE9);

    applyStimulus(1'b0, 11);
    checkOutput("edge20 big", outBig, FULL);
    checkOutput("edge20 small", outSmall, TRUNC);

    applyStimulus(1'b0, 30);
    checkOutput("edge50 big", outBig, FULL);
    checkOutput("edge50 small", outSmall, TRUNC);

    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 11);
    applyStimulus(1'b1, 2);
    checkOutput("midrun reset big", outBig, ZERO);
    checkOutput("midrun reset small", outSmall, ZERO);

    applyStimulus(1'b0, 19);
    checkOutput("rerun big", outBig, FULL);
    checkOutput("rerun small", outSmall, TRUNC);

    applyStimulus(1'b0, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
